// File: rtl/bitwise_unit_arbiter_pkg.sv
// Shared opcode constants and response-register state encoding for the
// two-requester bitwise unit arbiter.
package bitwise_unit_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/bitwise_unit_arbiter_bitwise_logic_unit.sv
// Combinational bitwise logic unit: AND, OR, NOT a, XOR on WIDTH-bit operands.
// No carries cross bit positions, so the result is always exactly WIDTH bits.
module bitwise_logic_unit
  import bitwise_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] or_res;
  logic [WIDTH-1:0] not_res;
  logic [WIDTH-1:0] xor_res;

  assign and_res = a & b;
  assign or_res  = a | b;
  assign not_res = ~a;
  assign xor_res = a ^ b;

  always_comb begin
    result = and_res;
    case (op)
      OP_AND:  result = and_res;
      OP_OR:   result = or_res;
      OP_NOT:  result = not_res;
      OP_XOR:  result = xor_res;
      default: result = and_res;
    endcase
  end

endmodule

// File: rtl/bitwise_unit_arbiter.sv
// Two requesters share one bitwise logic unit through a round-robin arbiter;
// the result is held in a single response register with valid/ready output.
module bitwise_unit_arbiter
  import bitwise_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready
);

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] alu_result;

  // Round-robin: on a tie the requester not served last time wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end
  end

  assign rsp_valid  = (state == FULL);
  assign can_accept = (state == EMPTY) || (rsp_valid && rsp_ready);

  // Readies are masked while reset is held so nothing transfers during reset.
  assign req0_ready = !reset && can_accept && req0_valid && !grant;
  assign req1_ready = !reset && can_accept && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

  bitwise_logic_unit #(
    .WIDTH(WIDTH)
  ) u_logic (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .result (alu_result)
  );

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (rsp_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant <= grant;
        rsp_id     <= grant;
        rsp_data   <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Directed bench for bitwise_unit_arbiter: reset, single requests, ties,
// fairness, backpressure and asynchronous reset with a pending result.
module tb_bitwise_unit_arbiter;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0;
  logic [1:0]   req0_op = 2'b00;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [1:0]   req1_op = 2'b00;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic         req1_ready;
  logic         rsp_valid;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic         rsp_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  bitwise_unit_arbiter #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset held with both requesters valid: nothing may be accepted.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    chk("rst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;

    // Tie after reset: req0 NOT 0, req1 XOR AAAA..^5555..
    rsp_ready = 1'b1;
    req0_op = 2'b10; req0_a = 32'h0000_0000; req0_b = 32'h1234_5678;
    req1_op = 2'b11; req1_a = 32'hAAAA_AAAA; req1_b = 32'h5555_5555;
    #1;
    chk("tie_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("tie_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    chk("tie1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("tie1_id", {31'd0, rsp_id}, 32'd0);
    chk("tie1_data", rsp_data, 32'hFFFF_FFFF);
    chk("tie2_req1_ready", {31'd0, req1_ready}, 32'd1);
    chk("tie2_req0_ready", {31'd0, req0_ready}, 32'd0);
    step();
    chk("tie2_id", {31'd0, rsp_id}, 32'd1);
    chk("tie2_data", rsp_data, 32'hFFFF_FFFF);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk("drain_empty", {31'd0, rsp_valid}, 32'd0);

    // Single request on req0 (AND), then req1 (OR) back to back.
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00;
    #1;
    chk("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    step();
    chk("single_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_id", {31'd0, rsp_id}, 32'd0);
    chk("single_data", rsp_data, 32'hF000_F000);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'h1234_0000; req1_b = 32'h0000_5678;
    #1;
    chk("or_req1_ready", {31'd0, req1_ready}, 32'd1);
    step();
    chk("or_id", {31'd0, rsp_id}, 32'd1);
    chk("or_data", rsp_data, 32'h1234_5678);

    // Fairness: both valid for 6 cycles, grants alternate starting with 0.
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'hFFFF_0000; req0_b = 32'h0F0F_0F0F;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'h0000_FFFF; req1_b = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("fair%0d_req0_ready", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("fair%0d_req1_ready", i), {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("fair%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("fair%0d_id", i), {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("fair%0d_data", i), rsp_data, (i % 2 == 0) ? 32'hF0F0_0F0F : 32'hFFFF_0000);
    end

    // Backpressure: result pending from req1, consumer stalls for 4 cycles.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp%0d_req0_ready", i), {31'd0, req0_ready}, 32'd0);
      chk($sformatf("bp%0d_req1_ready", i), {31'd0, req1_ready}, 32'd0);
      step();
      chk($sformatf("bp%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_id", i), {31'd0, rsp_id}, 32'd1);
      chk($sformatf("bp%0d_data", i), rsp_data, 32'hFFFF_0000);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_req0_ready", {31'd0, req0_ready}, 32'd1);
    step();
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_release_id", {31'd0, rsp_id}, 32'd0);
    chk("bp_release_data", rsp_data, 32'hF0F0_0F0F);

    // Load 0x12345678 via req1 OR, then reset asynchronously while FULL.
    req0_valid = 1'b0;
    req1_op = 2'b01; req1_a = 32'h1234_0000; req1_b = 32'h0000_5678;
    step();
    chk("pre_rst_data", rsp_data, 32'h1234_5678);
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_rst_data", rsp_data, 32'h0);
    chk("async_rst_id", {31'd0, rsp_id}, 32'd0);
    step();
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_0000;
    #1;
    chk("post_rst_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    chk("post_rst_id", {31'd0, rsp_id}, 32'd0);
    chk("post_rst_data", rsp_data, 32'h0000_00FF);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
